// File: rtl/fp_pkg.sv
// Shared FP rounding definitions: rounding-mode encodings, datapath widths
// and the operand payload carried through the rounding pipeline.
package fp_pkg;

    localparam int unsigned EXP_FRAC_W = 65;
    localparam int unsigned GRS_W      = 3;
    localparam int unsigned RM_W       = 3;

    localparam logic [RM_W-1:0] RM_RNE = 3'b000;
    localparam logic [RM_W-1:0] RM_RZ  = 3'b001;
    localparam logic [RM_W-1:0] RM_RDN = 3'b010;
    localparam logic [RM_W-1:0] RM_RUP = 3'b011;
    localparam logic [RM_W-1:0] RM_RMM = 3'b100;
    localparam logic [RM_W-1:0] RM_DYN = 3'b111;

    typedef struct packed {
        logic [EXP_FRAC_W-1:0] exp_frac;
        logic [GRS_W-1:0]      grs;
        logic                  sign;
        logic [RM_W-1:0]       rm;
    } round_op_t;

endpackage

// File: rtl/fp_round_arbiter_if.sv
// Request and result bus of the shared rounding datapath.
interface fp_round_arbiter_if
    import fp_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned TAGW = 6,
    parameter int unsigned SRCW = 2
);

    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ*EXP_FRAC_W-1:0] req_exp_frac;
    logic [NREQ*GRS_W-1:0]      req_grs;
    logic [NREQ-1:0]            req_sign;
    logic [NREQ*RM_W-1:0]       req_rm;
    logic [NREQ*TAGW-1:0]       req_tag;

    logic                       out_valid;
    logic                       out_ready;
    logic [SRCW-1:0]            out_src;
    logic [TAGW-1:0]            out_tag;
    logic [EXP_FRAC_W-1:0]      out_exp_frac;
    logic                       out_inexact;
    logic                       out_illegal_rm;

    modport master (
        output req_valid, req_exp_frac, req_grs, req_sign, req_rm, req_tag, out_ready,
        input  req_ready, out_valid, out_src, out_tag, out_exp_frac, out_inexact, out_illegal_rm
    );

    modport slave (
        input  req_valid, req_exp_frac, req_grs, req_sign, req_rm, req_tag, out_ready,
        output req_ready, out_valid, out_src, out_tag, out_exp_frac, out_inexact, out_illegal_rm
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the pointer with wrap, pointer moves past
// the winner only when the grant is actually taken (advance).
module rr_arbiter #(
    parameter int unsigned N = 3,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] ptr;
    logic          found;
    int            j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < int'(N); k++) begin
            j = int'(ptr) + k;
            if (j >= int'(N)) j = j - int'(N);
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(idx) == int'(N) - 1) ? '0 : IW'(int'(idx) + 1);
        end
    end

endmodule

// File: rtl/fp_round_arbiter.sv
// Shares one double-precision rounder among the FP units: round-robin grant,
// S1 captures operands with the resolved mode, S2 holds the rounded result.
module fp_round_arbiter
    import fp_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned TAGW = 6,
    parameter int unsigned SRCW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [RM_W-1:0] frm_csr,
    fp_round_arbiter_if.slave bus
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       grant;
    logic [IW-1:0]         grant_idx;
    logic                  s1_load;
    logic                  s2_load;
    logic                  accept;

    round_op_t             sel_op;
    logic [RM_W-1:0]       sel_rm;
    logic [TAGW-1:0]       sel_tag;

    logic                  s1_valid;
    round_op_t             s1_op;
    logic [SRCW-1:0]       s1_src;
    logic [TAGW-1:0]       s1_tag;

    logic                  inc;
    logic                  inexact;
    logic                  illegal;
    logic [EXP_FRAC_W-1:0] rounded;

    assign s2_load       = s1_valid & (~bus.out_valid | bus.out_ready);
    assign s1_load       = ~s1_valid | s2_load;
    assign accept        = (|grant) & s1_load & ~flush & ~rst;
    assign bus.req_ready = grant & {NREQ{s1_load & ~flush & ~rst}};

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .advance (accept),
        .grant   (grant),
        .idx     (grant_idx)
    );

    // Operand mux from the one-hot grant; dynamic mode resolves against frm now.
    always_comb begin
        sel_op  = '0;
        sel_rm  = '0;
        sel_tag = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant[i]) begin
                sel_op.exp_frac = bus.req_exp_frac[i*EXP_FRAC_W +: EXP_FRAC_W];
                sel_op.grs      = bus.req_grs[i*GRS_W +: GRS_W];
                sel_op.sign     = bus.req_sign[i];
                sel_rm          = bus.req_rm[i*RM_W +: RM_W];
                sel_tag         = bus.req_tag[i*TAGW +: TAGW];
            end
        end
        sel_op.rm = (sel_rm == RM_DYN) ? frm_csr : sel_rm;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_src   <= '0;
            s1_tag   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= accept;
            if (accept) begin
                s1_op  <= sel_op;
                s1_src <= SRCW'(grant_idx);
                s1_tag <= sel_tag;
            end
        end
    end

    // Round-up decision; reserved modes truncate and are flagged.
    always_comb begin
        inexact = |s1_op.grs;
        illegal = 1'b0;
        inc     = 1'b0;
        case (s1_op.rm)
            RM_RNE:  inc = s1_op.grs[2] & (s1_op.exp_frac[0] | s1_op.grs[1] | s1_op.grs[0]);
            RM_RZ:   inc = 1'b0;
            RM_RDN:  inc = s1_op.sign & inexact;
            RM_RUP:  inc = ~s1_op.sign & inexact;
            RM_RMM:  inc = s1_op.grs[2];
            default: illegal = 1'b1;
        endcase
        rounded = s1_op.exp_frac + EXP_FRAC_W'(inc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid      <= 1'b0;
            bus.out_src        <= '0;
            bus.out_tag        <= '0;
            bus.out_exp_frac   <= '0;
            bus.out_inexact    <= 1'b0;
            bus.out_illegal_rm <= 1'b0;
        end else if (flush) begin
            bus.out_valid <= 1'b0;
        end else if (s2_load) begin
            bus.out_valid      <= 1'b1;
            bus.out_src        <= s1_src;
            bus.out_tag        <= s1_tag;
            bus.out_exp_frac   <= rounded;
            bus.out_inexact    <= inexact;
            bus.out_illegal_rm <= illegal;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule
